// File: rtl/seven_segment_capture.sv
// Recovers the digits shown on a multiplexed active-low 4-digit seven-segment
// display by sampling anode/segment once they are stable. Results are
// accumulated over a fixed capture window and published once per window.
module seven_segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] data_out,
  output logic [3:0]  digit_display_out,
  output logic [3:0]  digit_point_out,
  output logic        frame_valid,
  output logic        data_changed,
  output logic        decode_err,
  output logic        anode_err
);

  localparam int unsigned WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  // Registered inputs {anode, segment} and stability tracking
  logic [11:0]   in_q;
  logic [7:0]    settle_q, settle_d;
  logic [WW-1:0] win_q, win_d;

  // Per-window accumulators
  logic [3:0]  seen_q, seen_d;
  logic [3:0]  dp_q, dp_d;
  logic [15:0] nib_q, nib_d;
  logic        derr_q, derr_d;
  logic        aerr_q, aerr_d;

  // Published outputs (also serve as the previous publication)
  logic [15:0] data_q, data_d;
  logic [3:0]  disp_q, disp_d;
  logic [3:0]  pt_q, pt_d;
  logic        fv_q, fv_d;
  logic        chg_q, chg_d;
  logic        derr_out_q, derr_out_d;
  logic        aerr_out_q, aerr_out_d;

  logic       strobe, tc;
  logic       an_one, an_multi;
  logic [1:0] idx;
  logic [4:0] dec;

  // Returns {valid, nibble} for a segments g..a pattern
  function automatic logic [4:0] decode7(input logic [6:0] s);
    case (s)
      7'h40: decode7 = 5'h10;
      7'h79: decode7 = 5'h11;
      7'h24: decode7 = 5'h12;
      7'h30: decode7 = 5'h13;
      7'h19: decode7 = 5'h14;
      7'h12: decode7 = 5'h15;
      7'h02: decode7 = 5'h16;
      7'h78: decode7 = 5'h17;
      7'h00: decode7 = 5'h18;
      7'h10: decode7 = 5'h19;
      7'h08: decode7 = 5'h1A;
      7'h03: decode7 = 5'h1B;
      7'h46: decode7 = 5'h1C;
      7'h21: decode7 = 5'h1D;
      7'h06: decode7 = 5'h1E;
      7'h0E: decode7 = 5'h1F;
      default: decode7 = 5'h00;
    endcase
  endfunction

  // settle_q clears on the edge in_q takes a new value, so it holds
  // (cycles held - 1); the strobe at SETTLE_CYCLES-1 is passed once per run
  // because the counter saturates one step beyond it.
  assign strobe = (settle_q == 8'(SETTLE_CYCLES - 1));
  assign tc     = (win_q == WW'(WINDOW_CYCLES - 1));
  assign dec    = decode7(in_q[6:0]);

  // Classify the registered anode pattern
  always_comb begin
    an_one = 1'b1;
    idx    = '0;
    case (in_q[11:8])
      4'hE:    idx = 2'd0;
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: an_one = 1'b0;
    endcase
    an_multi = !an_one && (in_q[11:8] != 4'hF);
  end

  // Next-state: settle/window counters, capture into accumulators, publication
  always_comb begin
    settle_d   = settle_q;
    win_d      = tc ? '0 : win_q + WW'(1);
    seen_d     = seen_q;
    dp_d       = dp_q;
    nib_d      = nib_q;
    derr_d     = derr_q;
    aerr_d     = aerr_q;
    data_d     = data_q;
    disp_d     = disp_q;
    pt_d       = pt_q;
    fv_d       = 1'b0;
    chg_d      = 1'b0;
    derr_out_d = derr_out_q;
    aerr_out_d = aerr_out_q;

    if ({anode, segment} != in_q) begin
      settle_d = '0;
    end else if (settle_q < 8'(SETTLE_CYCLES)) begin
      settle_d = settle_q + 8'd1;
    end

    if (strobe) begin
      if (an_multi) begin
        aerr_d = 1'b1;
      end else if (an_one) begin
        seen_d[idx] = 1'b1;
        dp_d[idx]   = ~in_q[7];
        if (dec[4]) begin
          nib_d[{idx, 2'b00} +: 4] = dec[3:0];
        end else begin
          derr_d = 1'b1;
        end
      end
    end

    // Publish from the post-capture values so a terminal-count strobe lands
    // in the closing window, then clear the accumulators.
    if (tc) begin
      data_d = '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (seen_d[i]) data_d[4*i +: 4] = nib_d[4*i +: 4];
      end
      disp_d     = seen_d;
      pt_d       = dp_d & seen_d;
      derr_out_d = derr_d;
      aerr_out_d = aerr_d;
      fv_d       = 1'b1;
      chg_d      = ({data_d, disp_d, pt_d} != {data_q, disp_q, pt_q});
      seen_d     = '0;
      dp_d       = '0;
      nib_d      = '0;
      derr_d     = 1'b0;
      aerr_d     = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q       <= 12'hFFF;
      settle_q   <= '0;
      win_q      <= '0;
      seen_q     <= '0;
      dp_q       <= '0;
      nib_q      <= '0;
      derr_q     <= 1'b0;
      aerr_q     <= 1'b0;
      data_q     <= '0;
      disp_q     <= '0;
      pt_q       <= '0;
      fv_q       <= 1'b0;
      chg_q      <= 1'b0;
      derr_out_q <= 1'b0;
      aerr_out_q <= 1'b0;
    end else begin
      in_q       <= {anode, segment};
      settle_q   <= settle_d;
      win_q      <= win_d;
      seen_q     <= seen_d;
      dp_q       <= dp_d;
      nib_q      <= nib_d;
      derr_q     <= derr_d;
      aerr_q     <= aerr_d;
      data_q     <= data_d;
      disp_q     <= disp_d;
      pt_q       <= pt_d;
      fv_q       <= fv_d;
      chg_q      <= chg_d;
      derr_out_q <= derr_out_d;
      aerr_out_q <= aerr_out_d;
    end
  end

  assign data_out          = data_q;
  assign digit_display_out = disp_q;
  assign digit_point_out   = pt_q;
  assign frame_valid       = fv_q;
  assign data_changed      = chg_q;
  assign decode_err        = derr_out_q;
  assign anode_err         = aerr_out_q;

endmodule
